// File: rtl/zion_riscv_isa_lib_pc_redirect_pkg.sv
// rtl/zion_riscv_isa_lib_pc_redirect_pkg.sv - shared types and widths for the fetch/redirect block
// Purpose: fetch FSM state encoding, instruction width and address-width derivation.
// Ports: none (package).
package zion_riscv_isa_lib_pc_redirect_pkg;

    localparam int INST_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetchState_e;

    function automatic int cpuWidth(input bit rv64);
        return rv64 ? 64 : 32;
    endfunction

endpackage

// File: rtl/zion_riscv_isa_lib_fetch_fifo.sv
// rtl/zion_riscv_isa_lib_fetch_fifo.sv - instruction buffer holding {pc, inst} entries
// Purpose: small FIFO between fetch responses and decode, with synchronous clear.
// Ports: clk/rst_n; iClr clears all entries; iPush/iPushPc/iPushData write;
//        iPop consumes head; oValid/oPc/oData present head; oCount occupancy.
module zion_riscv_isa_lib_fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iClr,
    input  logic              iPush,
    input  logic [PC_W-1:0]   iPushPc,
    input  logic [DATA_W-1:0] iPushData,
    input  logic              iPop,
    output logic              oValid,
    output logic [PC_W-1:0]   oPc,
    output logic [DATA_W-1:0] oData,
    output logic [CNT_W-1:0]  oCount
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PC_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] count;
    logic doPush, doPop;

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign doPop  = iPop && (count != '0);
    assign doPush = iPush && ((count != FULL) || doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (iClr) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= (wrPtr == LAST) ? '0 : wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= (rdPtr == LAST) ? '0 : rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !iClr) mem[wrPtr] <= {iPushPc, iPushData};
    end

    assign oValid = (count != '0);
    assign {oPc, oData} = mem[rdPtr];
    assign oCount = count;

endmodule

// File: rtl/zion_riscv_isa_lib_pc_redirect.sv
// rtl/zion_riscv_isa_lib_pc_redirect.sv - fetch PC sequencer with branch redirect and in-flight drop
// Purpose: issues sequential fetch requests, buffers responses for decode, and on a taken
//          aligned branch/jump redirects the PC, clears the buffer and drops stale responses.
// Ports: clk/rst_n; iBjValid/iBjEn/iTgtAddr resolved branch; oFetchReqValid/iFetchReqReady/
//        oFetchAddr request; iFetchRspValid/iFetchRspData response; oInstValid/iInstReady/
//        oInstData/oInstPc delivery; oFlush redirect strobe; oMisalign misaligned-target pulse.
module zion_riscv_isa_lib_pc_redirect
    import zion_riscv_isa_lib_pc_redirect_pkg::*;
#(
    parameter bit RV64 = 1'b0,
    localparam int CPU_WIDTH = cpuWidth(RV64),
    parameter logic [CPU_WIDTH-1:0] RESET_PC = '0,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iBjValid,
    input  logic                  iBjEn,
    input  logic [CPU_WIDTH-1:0]  iTgtAddr,
    output logic                  oFetchReqValid,
    input  logic                  iFetchReqReady,
    output logic [CPU_WIDTH-1:0]  oFetchAddr,
    input  logic                  iFetchRspValid,
    input  logic [INST_WIDTH-1:0] iFetchRspData,
    output logic                  oInstValid,
    input  logic                  iInstReady,
    output logic [INST_WIDTH-1:0] oInstData,
    output logic [CPU_WIDTH-1:0]  oInstPc,
    output logic                  oFlush,
    output logic                  oMisalign
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_OUTSTANDING);

    fetchState_e state, stateNext;
    logic [CPU_WIDTH-1:0] pc, pcNext, rspPc;
    logic [CNT_W-1:0] outstanding, outNext, dropCnt, dropNext, bufCount;
    logic misalignQ;
    logic taken, redirect, misalignTgt, reqFire, rspCounted, bufPush, bufPop;

    assign taken       = iBjValid & iBjEn;
    assign redirect    = taken & (iTgtAddr[1:0] == 2'b00);
    assign misalignTgt = taken & (iTgtAddr[1:0] != 2'b00);

    // Requests stop once every buffer slot is spoken for by a request or a held entry.
    assign oFetchReqValid = (state == FETCH) && (({1'b0, outstanding} + {1'b0, bufCount}) < MAX_CNT);
    assign oFetchAddr     = pc;
    assign reqFire        = oFetchReqValid & iFetchReqReady;

    assign rspCounted = iFetchRspValid && (state != IDLE) && (outstanding != '0);
    assign bufPush    = rspCounted && (state == FETCH) && !redirect;
    assign bufPop     = oInstValid & iInstReady;

    // In FETCH every outstanding request belongs to the current sequential run ending at
    // pc-4, so the oldest one (the one this response answers) sits at pc - 4*outstanding.
    assign rspPc = pc - {{(CPU_WIDTH - CNT_W - 2){1'b0}}, outstanding, 2'b00};

    assign oFlush    = redirect;
    assign oMisalign = misalignQ;

    always_comb begin
        outNext   = outstanding + CNT_W'(reqFire) - CNT_W'(rspCounted);
        dropNext  = dropCnt;
        pcNext    = pc;
        stateNext = state;
        case (state)
            IDLE:  stateNext = FETCH;
            FETCH: if (reqFire) pcNext = pc + CPU_WIDTH'(4);
            DRAIN: begin
                if (rspCounted) dropNext = dropCnt - CNT_W'(1);
                if (dropNext == '0) stateNext = FETCH;
            end
            default: stateNext = IDLE;
        endcase
        // Everything still in flight after this cycle, including a request accepted now,
        // belongs to the abandoned path.
        if (redirect) begin
            pcNext    = iTgtAddr;
            dropNext  = outNext;
            stateNext = (outNext != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
            misalignQ   <= 1'b0;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            outstanding <= outNext;
            dropCnt     <= dropNext;
            misalignQ   <= misalignTgt;
        end
    end

    zion_riscv_isa_lib_fetch_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .PC_W   (CPU_WIDTH),
        .DATA_W (INST_WIDTH)
    ) u_fetchFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .iClr      (redirect),
        .iPush     (bufPush),
        .iPushPc   (rspPc),
        .iPushData (iFetchRspData),
        .iPop      (bufPop),
        .oValid    (oInstValid),
        .oPc       (oInstPc),
        .oData     (oInstData),
        .oCount    (bufCount)
    );

endmodule

// File: tb/tb_zion_riscv_isa_lib_pc_redirect.sv
// tb/tb_zion_riscv_isa_lib_pc_redirect.sv - directed scoreboard bench for the fetch/redirect block
module tb_zion_riscv_isa_lib_pc_redirect;

    logic        clk;
    logic        rst_n;
    logic        iBjValid, iBjEn;
    logic [31:0] iTgtAddr;
    logic        oFetchReqValid, iFetchReqReady;
    logic [31:0] oFetchAddr;
    logic        iFetchRspValid;
    logic [31:0] iFetchRspData;
    logic        oInstValid, iInstReady;
    logic [31:0] oInstData, oInstPc;
    logic        oFlush, oMisalign;

    int checks = 0;
    int errors = 0;
    int fetchCount = 0;
    bit memHold = 1'b0;
    logic [31:0] memAddr;
    logic [31:0] expFetchQ [$];
    logic [31:0] expInstQ [$];
    logic [31:0] pendQ [$];

    zion_riscv_isa_lib_pc_redirect #(
        .RV64            (1'b0),
        .RESET_PC        (32'h100),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iBjValid       (iBjValid),
        .iBjEn          (iBjEn),
        .iTgtAddr       (iTgtAddr),
        .oFetchReqValid (oFetchReqValid),
        .iFetchReqReady (iFetchReqReady),
        .oFetchAddr     (oFetchAddr),
        .iFetchRspValid (iFetchRspValid),
        .iFetchRspData  (iFetchRspData),
        .oInstValid     (oInstValid),
        .iInstReady     (iInstReady),
        .oInstData      (oInstData),
        .oInstPc        (oInstPc),
        .oFlush         (oFlush),
        .oMisalign      (oMisalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'h13A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while ((expFetchQ.size() > 0 || expInstQ.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_fetch_left"}, 64'(expFetchQ.size()), 64'd0);
        chk({tag, "_inst_left"}, 64'(expInstQ.size()), 64'd0);
    endtask

    task automatic branch(input logic valid, input logic en, input logic [31:0] tgt);
        iBjValid = valid;
        iBjEn    = en;
        iTgtAddr = tgt;
    endtask

    // Memory with one-cycle in-order responses plus the fetch/delivery scoreboard.
    initial begin
        iFetchRspValid = 1'b0;
        iFetchRspData  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!memHold && pendQ.size() > 0) begin
                memAddr = pendQ.pop_front();
                iFetchRspValid = 1'b1;
                iFetchRspData  = memData(memAddr);
            end else begin
                iFetchRspValid = 1'b0;
                iFetchRspData  = '0;
            end
            #3;
            if (oFetchReqValid && iFetchReqReady) begin
                pendQ.push_back(oFetchAddr);
                fetchCount++;
                if (expFetchQ.size() > 0) chk("fetch_addr", 64'(oFetchAddr), 64'(expFetchQ.pop_front()));
            end
            if (oInstValid && iInstReady) begin
                chk("inst_data", 64'(oInstData), 64'(memData(oInstPc)));
                if (expInstQ.size() > 0) chk("inst_pc", 64'(oInstPc), 64'(expInstQ.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        branch(1'b0, 1'b0, 32'h0);
        iFetchReqReady = 1'b1;
        iInstReady     = 1'b1;

        // Reset state and sequential fetch from RESET_PC
        repeat (2) @(negedge clk);
        #4;
        chk("rst_req_valid", 64'(oFetchReqValid), 64'd0);
        chk("rst_inst_valid", 64'(oInstValid), 64'd0);
        chk("rst_misalign", 64'(oMisalign), 64'd0);
        chk("rst_flush", 64'(oFlush), 64'd0);
        expFetchQ.push_back(32'h100); expFetchQ.push_back(32'h104); expFetchQ.push_back(32'h108);
        expInstQ.push_back(32'h100);  expInstQ.push_back(32'h104);  expInstQ.push_back(32'h108);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        chk("idle_no_req", 64'(oFetchReqValid), 64'd0);
        @(negedge clk);
        #4;
        chk("first_req_valid", 64'(oFetchReqValid), 64'd1);
        chk("first_req_addr", 64'(oFetchAddr), 64'h100);
        waitDrain("seq", 40);

        // Two requests in flight, redirect to 0x200 drains both
        @(negedge clk);
        memHold = 1'b1;
        repeat (8) @(negedge clk);
        branch(1'b1, 1'b1, 32'h200);
        expFetchQ.push_back(32'h200);
        expInstQ.push_back(32'h200);
        #4;
        chk("drain_buf_empty", 64'(oInstValid), 64'd0);
        chk("drain_flush", 64'(oFlush), 64'd1);
        chk("drain_redir_noreq", 64'(oFetchReqValid), 64'd0);
        @(negedge clk);
        branch(1'b0, 1'b0, 32'h0);
        #4;
        chk("drain_noreq", 64'(oFetchReqValid), 64'd0);
        chk("drain_flush_low", 64'(oFlush), 64'd0);
        @(negedge clk);
        memHold = 1'b0;
        waitDrain("drain", 40);

        // Redirect coinciding with a request handshake and a response
        @(negedge clk);
        iInstReady = 1'b0;
        repeat (8) @(negedge clk);
        branch(1'b1, 1'b1, 32'h100);
        expFetchQ.push_back(32'h100); expFetchQ.push_back(32'h104); expFetchQ.push_back(32'h300);
        expInstQ.push_back(32'h300);
        #4;
        chk("quiet_redir_flush", 64'(oFlush), 64'd1);
        @(negedge clk);
        branch(1'b0, 1'b0, 32'h0);
        iInstReady = 1'b1;
        @(negedge clk);
        branch(1'b1, 1'b1, 32'h300);
        #4;
        chk("same_req_valid", 64'(oFetchReqValid), 64'd1);
        chk("same_req_addr", 64'(oFetchAddr), 64'h104);
        chk("same_flush", 64'(oFlush), 64'd1);
        @(negedge clk);
        branch(1'b0, 1'b0, 32'h0);
        #4;
        chk("same_drain_noreq", 64'(oFetchReqValid), 64'd0);
        chk("same_rsp_dropped", 64'(oInstValid), 64'd0);
        waitDrain("same", 40);

        // Not-taken and misaligned taken targets leave the PC alone
        @(negedge clk);
        iInstReady = 1'b0;
        repeat (8) @(negedge clk);
        branch(1'b1, 1'b1, 32'h400);
        expFetchQ.push_back(32'h400); expFetchQ.push_back(32'h404); expFetchQ.push_back(32'h408);
        @(negedge clk);
        branch(1'b0, 1'b0, 32'h0);
        repeat (8) @(negedge clk);
        branch(1'b1, 1'b0, 32'h700);
        #4;
        chk("nt_flush", 64'(oFlush), 64'd0);
        @(negedge clk);
        branch(1'b1, 1'b1, 32'h202);
        #4;
        chk("mis_noflush", 64'(oFlush), 64'd0);
        chk("mis_pre", 64'(oMisalign), 64'd0);
        @(negedge clk);
        branch(1'b0, 1'b0, 32'h0);
        #4;
        chk("mis_pulse", 64'(oMisalign), 64'd1);
        @(negedge clk);
        #4;
        chk("mis_pulse_end", 64'(oMisalign), 64'd0);
        chk("mis_buf_kept", 64'(oInstValid), 64'd1);
        chk("mis_noreq", 64'(oFetchReqValid), 64'd0);
        @(negedge clk);
        expInstQ.push_back(32'h400); expInstQ.push_back(32'h404); expInstQ.push_back(32'h408);
        iInstReady = 1'b1;
        waitDrain("mis", 40);

        // Decode stalled: only MAX_OUTSTANDING requests, one more per pop
        @(negedge clk);
        iInstReady = 1'b0;
        repeat (8) @(negedge clk);
        branch(1'b1, 1'b1, 32'h500);
        fetchCount = 0;
        expFetchQ.push_back(32'h500); expFetchQ.push_back(32'h504); expFetchQ.push_back(32'h508);
        expInstQ.push_back(32'h500);
        @(negedge clk);
        branch(1'b0, 1'b0, 32'h0);
        repeat (10) @(negedge clk);
        #4;
        chk("bp_count", 64'(fetchCount), 64'd2);
        chk("bp_noreq", 64'(oFetchReqValid), 64'd0);
        chk("bp_full", 64'(oInstValid), 64'd1);
        @(negedge clk);
        iInstReady = 1'b1;
        @(negedge clk);
        iInstReady = 1'b0;
        repeat (6) @(negedge clk);
        #4;
        chk("bp_count_after_pop", 64'(fetchCount), 64'd3);
        chk("bp_noreq_after_pop", 64'(oFetchReqValid), 64'd0);
        waitDrain("bp", 5);

        // Reset while draining two outstanding requests
        @(negedge clk);
        memHold = 1'b1;
        iInstReady = 1'b1;
        repeat (8) @(negedge clk);
        branch(1'b1, 1'b1, 32'h600);
        #4;
        chk("rd_flush", 64'(oFlush), 64'd1);
        @(negedge clk);
        branch(1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        memHold = 1'b0;
        #1;
        chk("rd_async_req", 64'(oFetchReqValid), 64'd0);
        chk("rd_async_inst", 64'(oInstValid), 64'd0);
        chk("rd_async_mis", 64'(oMisalign), 64'd0);
        repeat (4) @(negedge clk);
        #4;
        chk("rd_late_rsp_ignored", 64'(oInstValid), 64'd0);
        chk("rd_noreq", 64'(oFetchReqValid), 64'd0);
        expFetchQ.push_back(32'h100);
        expInstQ.push_back(32'h100);
        @(negedge clk);
        rst_n = 1'b1;
        waitDrain("restart", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
